// File: rtl/mem_stage.sv
// mem_stage -- memory-access pipeline stage.
// Decodes the operation from icode, issues one request on a req/ack memory
// port, and presents the loaded value (valM) and a fault flag (dmem_error)
// with a one-cycle out_valid strobe.
// Optional feature: define MEM_TIMEOUT_EN to abort an access that waits
// TIMEOUT cycles without mem_ack (reported as dmem_error = 1, valM = 0).
module mem_stage #(
    parameter int N         = 64,
    parameter int MEM_BYTES = 4096,
    parameter int TIMEOUT   = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   icode,
    input  logic [N-1:0] valE,
    input  logic [N-1:0] valA,
    input  logic [N-1:0] valP,
    output logic         mem_req,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_wdata,
    input  logic         mem_ack,
    input  logic [N-1:0] mem_rdata,
    output logic         out_valid,
    output logic [N-1:0] valM,
    output logic         dmem_error
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    // Highest byte address at which a full 8-byte word still fits.
    localparam logic [N-1:0] ADDR_MAX = N'(MEM_BYTES - 8);

    if (MEM_BYTES < 8 || TIMEOUT < 1) begin : g_param_check
        $error("mem_stage: MEM_BYTES must be >= 8 and TIMEOUT >= 1");
    end

    state_t         state, state_nx;
    logic           dec_mem, dec_we, dec_fault, accept, tmo_hit;
    logic [N-1:0]   dec_addr, dec_wdata;

    assign accept    = (state == S_IDLE) && in_valid;
    assign dec_fault = dec_mem && (dec_addr > ADDR_MAX);

    // Decode the operation: memory access or not, direction, address and data.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        dec_mem   = 1'b0;
        dec_we    = 1'b0;
        dec_addr  = valE;
        dec_wdata = valA;
        case (icode)
            4'd4:  begin dec_mem = 1'b1; dec_we = 1'b1; end                      // rmmovq
            4'd5:  begin dec_mem = 1'b1; end                                     // mrmovq
            4'd8:  begin dec_mem = 1'b1; dec_we = 1'b1; dec_wdata = valP; end    // call
            4'd9:  begin dec_mem = 1'b1; dec_addr = valA; end                    // ret
            4'd10: begin dec_mem = 1'b1; dec_we = 1'b1; end                      // pushq
            4'd11: begin dec_mem = 1'b1; dec_addr = valA; end                    // popq
            default: ;
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] tmo_cnt;

    // The abort fires at the end of the TIMEOUT-th unacknowledged WAIT cycle;
    // an ack in that same cycle wins.
    assign tmo_hit = (state == S_WAIT) && !mem_ack && (tmo_cnt == CW'(TIMEOUT - 1));

    // Count unacknowledged WAIT cycles; cleared whenever a new operation is accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            tmo_cnt <= '0;
        else if (accept)
            tmo_cnt <= '0;
        else if (state == S_WAIT && !mem_ack)
            tmo_cnt <= tmo_cnt + 1'b1;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nx;
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (in_valid) state_nx = (dec_mem && !dec_fault) ? S_WAIT : S_DONE;
            S_WAIT: if (mem_ack || tmo_hit) state_nx = S_DONE;
            S_DONE: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state.
    always_comb begin
        in_ready  = (state == S_IDLE);
        mem_req   = (state == S_WAIT);
        out_valid = (state == S_DONE);
    end

    // Request registers latch on acceptance; results change only on DONE entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            valM       <= '0;
            dmem_error <= 1'b0;
        end else begin
            if (accept) begin
                mem_addr  <= dec_addr;
                mem_wdata <= dec_wdata;
                mem_we    <= dec_mem && dec_we && !dec_fault;
                // Non-memory and out-of-range operations go straight to DONE.
                if (!dec_mem || dec_fault) begin
                    valM       <= '0;
                    dmem_error <= dec_fault;
                end
            end
            if (state == S_WAIT) begin
                if (mem_ack) begin
                    if (!mem_we)
                        valM <= mem_rdata;
                    dmem_error <= 1'b0;
                end else if (tmo_hit) begin
                    valM       <= '0;
                    dmem_error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter N, default 64: datapath and address width.
REQ-002 Parameter MEM_BYTES, default 4096: data-memory size in bytes.
REQ-003 Parameter TIMEOUT, default 16: maximum wait cycles for mem_ack; used only when MEM_TIMEOUT_EN is defined.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  execute-stage result present.
REQ-007 in_ready  output  1  stage can accept a new operation.
REQ-008 icode  input  4  instruction code.
REQ-009 valE  input  N  ALU result.
REQ-010 valA  input  N  register operand A.
REQ-011 valP  input  N  next-PC value.
REQ-012 mem_req  output  1  memory request, held until acknowledged.
REQ-013 mem_we  output  1  1 = write, 0 = read.
REQ-014 mem_addr  output  N  byte address.
REQ-015 mem_wdata  output  N  write data.
REQ-016 mem_ack  input  1  memory completion strobe.
REQ-017 mem_rdata  input  N  read data, valid when mem_ack = 1.
REQ-018 out_valid  output  1  one-cycle result strobe.
REQ-019 valM  output  N  loaded value.
REQ-020 dmem_error  output  1  memory fault for the completed operation.

Function
REQ-021 The FSM SHALL have three states:
- IDLE: in_ready = 1.
- WAIT: mem_req = 1.
- DONE: out_valid = 1.
REQ-022 In IDLE with in_valid = 1, the block SHALL latch icode, address and write data on the clock edge.
REQ-023 Address and data selection by icode SHALL be:
- 4 (rmmovq): write, address valE, data valA.
- 5 (mrmovq): read, address valE.
- 8 (call): write, address valE, data valP.
- 9 (ret): read, address valA.
- 10 (pushq): write, address valE, data valA.
- 11 (popq): read, address valA.
REQ-024 For any other icode, the FSM SHALL go IDLE->DONE with valM = 0 and dmem_error = 0, and SHALL NOT assert mem_req.
REQ-025 An address greater than MEM_BYTES-8 (unsigned) SHALL go IDLE->DONE with dmem_error = 1, valM = 0 and no mem_req.
REQ-026 A valid access SHALL go IDLE->WAIT; mem_req, mem_we, mem_addr and mem_wdata SHALL stay stable until mem_ack is sampled high.
REQ-027 In WAIT with mem_ack = 1, the block SHALL capture mem_rdata into valM for reads (valM unchanged for writes), set dmem_error = 0 and enter DONE.
REQ-028 DONE SHALL last exactly one cycle and then return to IDLE; in_ready SHALL be 0 in WAIT and DONE.
REQ-029 Latency SHALL be:
- non-memory or fault: out_valid one cycle after acceptance;
- memory access: mem_req asserted the cycle after acceptance, out_valid the cycle after mem_ack.
REQ-030 mem_ack SHALL be ignored in IDLE and DONE.
REQ-031 valM and dmem_error SHALL change only on entry to DONE and hold otherwise.
REQ-032 Alignment SHALL NOT be checked.

Reset
REQ-033 Reset SHALL force, immediately and regardless of clk:
- state to IDLE, in_ready = 1;
- mem_req, mem_we, out_valid and dmem_error to 0;
- mem_addr, mem_wdata and valM to 0;
- the timeout counter to 0.
REQ-034 Reset asserted during WAIT SHALL drop mem_req at once and abandon the access; a subsequent mem_ack SHALL have no effect.

Configuration
REQ-035 With MEM_TIMEOUT_EN defined:
- a counter SHALL clear on WAIT entry and increment each WAIT cycle without mem_ack;
- when it reaches TIMEOUT, the FSM SHALL drop mem_req, set dmem_error = 1 and valM = 0, and enter DONE;
- mem_ack in that same cycle SHALL take priority over the timeout.
REQ-036 Without MEM_TIMEOUT_EN, WAIT SHALL persist indefinitely until mem_ack, and no counter logic SHALL exist.

Verification
REQ-037 icode=5, valE=0x100; mem_ack 3 cycles later with rdata=0xDEADBEEF -> mem_req=1, mem_we=0, addr=0x100 for 3 cycles; out_valid next cycle; valM=0xDEADBEEF, dmem_error=0.
REQ-038 icode=8, valE=0x1F8, valP=0x40; immediate ack -> mem_we=1, addr=0x1F8, wdata=0x40; out_valid; valM unchanged.
REQ-039 icode=5, valE=0xFF9 (MEM_BYTES=4096) -> no mem_req; out_valid one cycle after accept; dmem_error=1, valM=0.
REQ-040 icode=6, in_valid back-to-back -> out_valid every other cycle; in_ready toggles 1/0; mem_req never asserted.
REQ-041 icode=11 accepted, reset pulsed during WAIT, then mem_ack -> mem_req=0 immediately; in_ready=1; out_valid stays 0.
REQ-042 With MEM_TIMEOUT_EN, TIMEOUT=16, icode=10 and no ack -> mem_req high for 16 cycles, then out_valid with dmem_error=1.
